l2_h2_nibble_assembler: RTL

- Receive-side counterpart of the low-2/high-2 byte pass-through path.
- Accepts a stream of DATA_W-bit words and extracts only the LANE_W lowest and LANE_W highest bits of each; the middle bits are ignored.
- Packs NBEATS consecutive extracted fields into one output word.
- Uses valid/ready handshakes on both sides and double-buffers (accumulator plus output register) so it sustains one beat per cycle under a continuously ready sink.

---
 rtl/l2_h2_nibble_assembler_pkg.sv | 15 +
 rtl/l2_h2_field_extract.sv | 28 ++
 rtl/l2_h2_nibble_assembler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/l2_h2_nibble_assembler_pkg.sv
// Shared types and helpers for the low-2/high-2 receive-side nibble assembler.
package l2_h2_nibble_assembler_pkg;

    // Assembler state: collecting beats, or a completed word parked in the accumulator.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Width of one extracted field (low lanes plus high lanes).
    function automatic int unsigned field_w(input int unsigned lane_w);
        return 2 * lane_w;
    endfunction

endpackage

// File: rtl/l2_h2_field_extract.sv
// Pulls the LANE_W lowest and LANE_W highest bits out of a DATA_W word.
// The high lanes land in the upper half of the field; middle bits are dropped.
module l2_h2_field_extract
    import l2_h2_nibble_assembler_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANE_W = 2
) (
    input  logic [DATA_W-1:0]           i_a,
    output logic [field_w(LANE_W)-1:0]  o_f
);

    // Lane-by-lane copy, written as loops to mirror the transmit-side extraction.
    always_comb begin
        o_f = '0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            o_f[i]          = i_a[i];
            o_f[LANE_W + i] = i_a[DATA_W - LANE_W + i];
        end
    end

    // The middle bits are intentionally ignored.
    if (DATA_W > 2 * LANE_W) begin : g_mid
        logic w_unused_mid;
        assign w_unused_mid = ^i_a[DATA_W-LANE_W-1:LANE_W];
    end

endmodule

// File: rtl/l2_h2_nibble_assembler.sv
// Packs NBEATS extracted fields into one output word with valid/ready on both
// sides. Accumulator plus output register give one beat per cycle while the
// sink keeps out_ready high.
module l2_h2_nibble_assembler
    import l2_h2_nibble_assembler_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned NBEATS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            a,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    output logic [NBEATS*2*LANE_W-1:0]   c,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_partial
);

    localparam int unsigned F_W   = field_w(LANE_W);
    localparam int unsigned OUT_W = NBEATS * F_W;
    localparam int unsigned CNT_W = $clog2(NBEATS);

    state_e             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic               r_acc_partial;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_c;
    logic               r_out_valid;
    logic               r_partial;

    logic [F_W-1:0]     w_f;
    logic [OUT_W-1:0]   w_acc_next;
    logic               w_accept;
    logic               w_drain;
    logic               w_last_beat;
    logic               w_complete;
    logic               w_partial;

    l2_h2_field_extract #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_extract (
        .i_a (a),
        .o_f (w_f)
    );

    assign in_ready    = rst && (r_state == FILL);
    assign w_accept    = in_valid && in_ready;
    assign w_drain     = r_out_valid && out_ready;
    assign w_last_beat = (r_cnt == CNT_W'(NBEATS - 1));
    assign w_complete  = w_accept && (w_last_beat || in_last);
    assign w_partial   = in_last && !w_last_beat;

    assign c           = r_c;
    assign out_valid   = r_out_valid;
    assign out_partial = r_partial;

    // Accumulator with the incoming field dropped into the slot for this beat.
    always_comb begin
        w_acc_next = r_acc;
        for (int unsigned k = 0; k < NBEATS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_acc_next[k*F_W +: F_W] = w_f;
            end
        end
    end

    // Fill/park state machine driving the accumulator and the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= FILL;
            r_acc         <= '0;
            r_acc_partial <= 1'b0;
            r_cnt         <= '0;
            r_c           <= '0;
            r_out_valid   <= 1'b0;
            r_partial     <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_drain) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_complete) begin
                            r_cnt <= '0;
                            // Output register free (or emptying now): load directly, else park.
                            if (!r_out_valid || w_drain) begin
                                r_c         <= w_acc_next;
                                r_partial   <= w_partial;
                                r_out_valid <= 1'b1;
                                r_acc       <= '0;
                            end else begin
                                r_acc         <= w_acc_next;
                                r_acc_partial <= w_partial;
                                r_state       <= FULL;
                            end
                        end else begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        r_c           <= r_acc;
                        r_partial     <= r_acc_partial;
                        r_acc         <= '0;
                        r_acc_partial <= 1'b0;
                        r_state       <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

endmodule
